// File: rtl/regfile_dump_reader_pkg.sv
// Constants and state encoding shared between the register file and its debug dump reader.
package regfile_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug-port sweeper for the register file: walks an address range on the debug read port
// and streams each {addr, data} word out over a valid/ready interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // ADDR  | read address presented, one settling cycle
  // WAIT  | latency down-counter running; capture on terminal count
  // SEND  | word held on out_* until the sink takes it
  // DONE  | one-cycle done pulse; busy drops on exit

  localparam int CNT_W = 3;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_pending, abort_d;
  logic                valid_d, olast_d, busy_d, done_d;
  logic [ADDR_W-1:0]   oaddr_d;
  logic [DATA_W-1:0]   odata_d;
  logic                stop_now;

  // an abort arriving on the handshake edge still ends the sweep at this word
  assign stop_now = out_last | abort_pending | abort;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rf_rd_addr    <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      abort_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      out_last      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_rd_addr    <= rd_addr_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      abort_pending <= abort_d;
      out_valid     <= valid_d;
      out_addr      <= oaddr_d;
      out_data      <= odata_d;
      out_last      <= olast_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_ADDR;
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_SEND;
      ST_SEND: if (out_ready) state_d = stop_now ? ST_DONE : ST_ADDR;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rf_rd_addr;
    last_d    = last_q;
    cnt_d     = cnt_q;
    abort_d   = abort_pending;
    valid_d   = out_valid;
    oaddr_d   = out_addr;
    odata_d   = out_data;
    olast_d   = out_last;
    busy_d    = busy;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_addr_d = first_addr;
          last_d    = last_addr;
          busy_d    = 1'b1;
          abort_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        cnt_d = CNT_W'(RD_LATENCY - 1);
        if (abort) abort_d = 1'b1;
      end
      ST_WAIT: begin
        if (abort) abort_d = 1'b1;
        if (cnt_q == '0) begin
          odata_d = rf_rd_data;
          oaddr_d = rf_rd_addr;
          olast_d = (rf_rd_addr == last_q) | abort_pending | abort;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (abort) abort_d = 1'b1;
        if (out_ready) begin
          valid_d = 1'b0;
          if (stop_now) done_d = 1'b1;
          else          rd_addr_d = rf_rd_addr + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: two builds (read latency 1 and 3) driven in lockstep,
// each with its own register-file model, scoreboard queue and output monitor.
module tb_regfile_dump_reader;

  typedef struct packed {
    logic [4:0] addr;
    logic       last;
  } item_t;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic       start      = 1'b0;
  logic [4:0] first_addr = '0;
  logic [4:0] last_addr  = '0;
  logic       out_ready  = 1'b0;
  logic       abort_s [2];

  int    cyc        = 0;
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    ready_mode = 0;
  bit    mut_mode   = 1'b0;
  item_t sb_q [2][$];
  int    ref_edge [2];
  int    done_cnt [2];
  int    s_edge, dn0, dn1;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s[lat%0d] at cycle %0d: got 0x%0h, expected 0x%0h",
               name, inst, cyc, act, want);
    end
  endfunction

  // register contents; in mutation mode every register changes every clock
  function automatic logic [31:0] reg_val(input logic [4:0] a, input int t, input bit m);
    logic [31:0] v;
    v = 32'hA5A5_0000 + {27'd0, a};
    if (m) v = v + {16'd0, 8'(t), 8'd0};
    return v;
  endfunction

  function automatic void push_sweep(input int f, input int l, input int stop_after);
    int    n;
    item_t it;
    n = ((l - f) & 31) + 1;
    if (stop_after >= 0 && stop_after < n) n = stop_after + 1;
    for (int j = 0; j < n; j++) begin
      it.addr = 5'((f + j) & 31);
      it.last = (j == n - 1);
      sb_q[0].push_back(it);
      sb_q[1].push_back(it);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [4:0]  rf_rd_addr, out_addr;
    logic [31:0] rf_rd_data, out_data;
    logic        out_valid, out_last, busy, done;
    logic [4:0]  apipe [LAT];

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .RD_LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .abort      (abort_s[g]),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
    );

    always @(posedge clock) begin
      apipe[0] <= rf_rd_addr;
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    always_comb rf_rd_data = reg_val(apipe[LAT-1], cyc, mut_mode);

    always @(negedge reset) begin
      #1;
      chk("rst_rf_rd_addr", LAT, 64'(rf_rd_addr), 64'(0));
      chk("rst_out_valid",  LAT, 64'(out_valid),  64'(0));
      chk("rst_out_addr",   LAT, 64'(out_addr),   64'(0));
      chk("rst_out_data",   LAT, 64'(out_data),   64'(0));
      chk("rst_out_last",   LAT, 64'(out_last),   64'(0));
      chk("rst_busy",       LAT, 64'(busy),       64'(0));
      chk("rst_done",       LAT, 64'(done),       64'(0));
    end

    initial begin : mon
      item_t       cur;
      logic [31:0] cur_data;
      bit          have, exp_done, chk_busy_low, prev_valid;
      have = 0; exp_done = 0; chk_busy_low = 0; prev_valid = 0;
      forever begin
        @(negedge clock);
        #1;
        if (!reset) begin
          have = 0; exp_done = 0; chk_busy_low = 0; prev_valid = 0;
        end else begin
          if (chk_busy_low) begin
            chk("busy_after_done", LAT, 64'(busy), 64'(0));
            chk_busy_low = 0;
          end
          if (done || exp_done) begin
            chk("done_pulse", LAT, 64'(done), 64'(exp_done));
            if (done) begin
              chk("busy_during_done", LAT, 64'(busy), 64'(1));
              done_cnt[g]++;
              chk_busy_low = 1;
            end
          end
          exp_done = 0;
          if (out_valid && !prev_valid) begin
            chk("word_expected", LAT, 64'(sb_q[g].size() != 0), 64'(1));
            if (sb_q[g].size() != 0) begin
              cur      = sb_q[g][0];
              have     = 1;
              cur_data = reg_val(cur.addr, ref_edge[g] + LAT + 1, mut_mode);
              chk("capture_latency", LAT, 64'(cyc - 1), 64'(ref_edge[g] + LAT + 1));
            end
          end
          if (out_valid && have) begin
            chk("out_addr", LAT, 64'(out_addr), 64'(cur.addr));
            chk("out_data", LAT, 64'(out_data), 64'(cur_data));
            chk("out_last", LAT, 64'(out_last), 64'(cur.last));
          end
          if (out_valid && out_ready && have) begin
            void'(sb_q[g].pop_front());
            exp_done    = cur.last;
            ref_edge[g] = cyc;
            have        = 0;
          end
          prev_valid = out_valid;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic issue_start(input int f, input int l, input bit abort_too);
    @(negedge clock);
    first_addr  = 5'(f);
    last_addr   = 5'(l);
    start       = 1'b1;
    abort_s[0]  = abort_too;
    abort_s[1]  = abort_too;
    ref_edge[0] = cyc;
    ref_edge[1] = cyc;
    s_edge      = cyc;
    dn0         = done_cnt[0];
    dn1         = done_cnt[1];
    @(negedge clock);
    start      = 1'b0;
    abort_s[0] = 1'b0;
    abort_s[1] = 1'b0;
  endtask

  // abort targets the WAIT phase of word 3 when the sink never stalls
  task automatic wait_done(input bit do_abort, input bit poke_start);
    bit fin;
    fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      abort_s[0] = do_abort && (cyc == s_edge + 3 * (1 + 2) + 2);
      abort_s[1] = do_abort && (cyc == s_edge + 3 * (3 + 2) + 2);
      start      = poke_start && (c == 4);
      if (start) begin
        first_addr = 5'd20;
        last_addr  = 5'd25;
      end
      @(negedge clock);
      fin = (done_cnt[0] > dn0) && (done_cnt[1] > dn1);
    end
    abort_s[0] = 1'b0;
    abort_s[1] = 1'b0;
    start      = 1'b0;
    chk("sweep_finished", 0, 64'(fin), 64'(1));
    repeat (2) @(negedge clock);
    chk("queue_drained", 1, 64'(sb_q[0].size()), 64'(0));
    chk("queue_drained", 3, 64'(sb_q[1].size()), 64'(0));
  endtask

  initial begin
    item_t one;
    abort_s[0] = 1'b0; abort_s[1] = 1'b0;
    ref_edge[0] = 0;   ref_edge[1] = 0;
    done_cnt[0] = 0;   done_cnt[1] = 0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    ready_mode = 0;
    push_sweep(0, 31, -1);  issue_start(0, 31, 0);  wait_done(0, 0);
    push_sweep(5, 5, -1);   issue_start(5, 5, 0);   wait_done(0, 0);

    ready_mode = 1;
    push_sweep(30, 1, -1);  issue_start(30, 1, 0);  wait_done(0, 0);

    ready_mode = 0;
    push_sweep(0, 31, 3);   issue_start(0, 31, 0);  wait_done(1, 0);

    @(negedge clock);
    abort_s[0] = 1'b1; abort_s[1] = 1'b1;
    @(negedge clock);
    abort_s[0] = 1'b0; abort_s[1] = 1'b0;
    push_sweep(7, 8, -1);   issue_start(7, 8, 0);   wait_done(0, 0);
    push_sweep(10, 12, -1); issue_start(10, 12, 1); wait_done(0, 0);

    ready_mode = 1;
    push_sweep(0, 3, -1);   issue_start(0, 3, 0);   wait_done(0, 1);

    for (int r = 0; r < 8; r++) begin
      int f, l;
      mut_mode = (r >= 4);
      f = $urandom_range(0, 31);
      l = (f + $urandom_range(0, 9)) & 31;
      push_sweep(f, l, -1); issue_start(f, l, 0); wait_done(0, 0);
    end
    mut_mode = 1'b0;

    ready_mode = 2;
    one.addr = 5'd0;
    one.last = 1'b0;
    sb_q[0].push_back(one);
    sb_q[1].push_back(one);
    issue_start(0, 31, 0);
    repeat (8) @(negedge clock);
    #3 reset = 1'b0;
    #2;
    sb_q[0].delete();
    sb_q[1].delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    ready_mode = 1;
    push_sweep(0, 1, -1);   issue_start(0, 1, 0);   wait_done(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
    $fatal(1);
  end

endmodule
